instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Front-end fetch stage that sits directly upstream of the instruction queue and feeds it.
- Owns the PC and issues one word read per cycle to a fixed-latency instruction memory (BRAM).
- Collects returned words in a small credit-managed buffer and pushes them to the queue under its ready/valid handshake.
- Supports a one-cycle redirect (branch/jump/mispredict) that discards all wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_LATENCY, 2, cycles from imem_addr_out sample to matching imem_data_in (>=1).
BUF_DEPTH, 4, response buffer entries; full throughput requires BUF_DEPTH >= MEM_LATENCY+2.

Ports:
clk_in  input  1  system clock, all state on rising edge.
rst_in  input  1  synchronous, active-high reset.
redirect_valid_in  input  1  redirect request this cycle.
redirect_pc_in  input  32  new PC; bits [1:0] ignored (treated as 0).
imem_req_out  output  1  read request valid this cycle.
imem_addr_out  output  32  byte address of request (word aligned).
imem_data_in  input  32  read data, valid exactly MEM_LATENCY cycles after the request.
iq_ready_in  input  1  queue can accept (driven by queue ready_out).
iq_valid_out  output  1  instruction presented (drives queue valid_in).
iq_instruction_out  output  32  instruction word (drives queue instruction_in).
iq_pc_out  output  32  PC of presented instruction (for later decode use).

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset (rst_in=1 at edge):
  - pc<=RESET_PC; shadow pipeline and buffer cleared.
  - imem_req_out=0, iq_valid_out=0, iq_instruction_out=0, iq_pc_out=0.
  - rst_in has priority over redirect.
- Issue: credit = (valid shadow stages) + (buffer occupancy), both registered.
  - imem_req_out=1 iff credit<BUF_DEPTH and no redirect this cycle.
  - imem_addr_out=pc. On issue, pc<=pc+4; wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Shadow pipeline: MEM_LATENCY stages of {valid, pc}, shifting every cycle, aligned with memory latency.
  - When the last stage is valid, imem_data_in is written into the buffer with that pc.
  - Invalid final stage: data ignored.
- Buffer: FIFO of {instruction, pc}.
  - iq_valid_out = not empty; head drives iq_instruction_out/iq_pc_out.
  - Pop on iq_valid_out && iq_ready_in.
  - Simultaneous push and pop permitted at any occupancy, including full.
  - Push into full is impossible by the credit rule; assert in simulation.
- Latency: request at cycle t -> buffer write at end of t+MEM_LATENCY -> iq_valid_out in cycle t+MEM_LATENCY+1. With MEM_LATENCY=2, first instruction after reset release is presented 3 cycles after first request.
- Handshake: while iq_ready_in=0, head instruction and pc held stable, iq_valid_out stays 1; issuing stops once credit reaches BUF_DEPTH.
- Redirect (redirect_valid_in=1 at edge):
  - pc<=redirect_pc_in&~3; all shadow valids cleared; buffer emptied.
  - No request issued and iq_valid_out forced 0 in the redirect cycle; no pop occurs.
  - First new-path request next cycle. Stale memory responses return to invalid shadow stages and are dropped.
- Redirect on consecutive cycles: last one wins; each cycle behaves as above.
- Reset mid-operation: identical to reset from idle; outstanding memory reads discarded.

Decomposition:
- Package fetch_pkg:
  - INST_WIDTH=32, XLEN=32, PC_STEP=4.
  - typedef fetch_entry_t {instruction, pc}.
  - typedef shadow_stage_t {valid, pc}.
- Sub-module fetch_buffer: parameterized FIFO of fetch_entry_t with push/pop/flush/count.
- Top holds pc, credit logic and the shadow pipeline.

Test Plan:
- Reset, iq_ready_in=1, memory returns word = address -> consecutive outputs (0x0,pc 0x0),(0x4,0x4),(0x8,0x8),(0xC,0xC); first iq_valid_out 3 cycles after first imem_req_out; one output per cycle thereafter.
- iq_ready_in=0 from reset -> exactly 4 requests (0x0..0xC), then imem_req_out=0; head stays 0x0. Release ready -> 0x0,0x4,0x8,0xC in order, then requests resume at 0x10.
- Redirect to 0x103 while 2 reads are in flight and 1 buffered -> next request addr 0x100; no stale word reaches the queue; first post-redirect output pc 0x100, 3 cycles after that request.
- Redirect asserted together with rst_in -> pc=RESET_PC, first request addr 0x0.
- Redirect to 0xFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Toggle iq_ready_in every cycle for 50 cycles -> output sequence gap-free and in order; no buffer overflow assertion fires.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths and record types for the fetch stage
// Contents: INST_WIDTH/XLEN/PC_STEP constants, fetch_entry_t (buffered word + its pc),
// shadow_stage_t (one in-flight memory read slot).
package fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam int XLEN       = 32;
  localparam int PC_STEP    = 4;

  typedef struct packed {
    logic [INST_WIDTH-1:0] instruction;
    logic [XLEN-1:0]       pc;
  } fetch_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } shadow_stage_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bus: redirect, instruction memory and queue handshake
// master: the fetch stage (drives imem request and queue push side).
// slave : the environment (redirect source, memory, instruction queue).
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic                  redirect_valid_in;
  logic [XLEN-1:0]       redirect_pc_in;
  logic                  imem_req_out;
  logic [XLEN-1:0]       imem_addr_out;
  logic [INST_WIDTH-1:0] imem_data_in;
  logic                  iq_ready_in;
  logic                  iq_valid_out;
  logic [INST_WIDTH-1:0] iq_instruction_out;
  logic [XLEN-1:0]       iq_pc_out;

  modport master (
    input  redirect_valid_in, redirect_pc_in,
    output imem_req_out, imem_addr_out,
    input  imem_data_in,
    input  iq_ready_in,
    output iq_valid_out, iq_instruction_out, iq_pc_out
  );

  modport slave (
    output redirect_valid_in, redirect_pc_in,
    input  imem_req_out, imem_addr_out,
    output imem_data_in,
    output iq_ready_in,
    input  iq_valid_out, iq_instruction_out, iq_pc_out
  );

endinterface

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - response FIFO of fetch_entry_t with push/pop/flush/count
// Ports: clk_i, rst_i (sync, active-high), flush_i (drop all entries), push_i/push_entry_i,
// pop_i, head_o (oldest entry), empty_o, count_o (occupancy).
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_entry_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush wins over any concurrent push/pop.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // The upstream credit rule must never let a push land in a full buffer
  // unless a pop frees a slot in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push && !do_pop) assert (count_q != CNT_W'(DEPTH));
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, credit-limited imem issue, shadow pipeline, response buffer
// Ports: clk_in (rising edge), rst_in (sync, active-high), fetch_if (master modport:
// redirect in, imem request/data, instruction queue valid/ready with instruction and pc).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  instruction_fetch_if.master fetch_if
);

  localparam int BCNT_W = $clog2(BUF_DEPTH + 1);
  localparam int CRED_W = $clog2(BUF_DEPTH + MEM_LATENCY + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  shadow_stage_t   shadow_q [MEM_LATENCY];
  shadow_stage_t   shadow_d [MEM_LATENCY];

  logic [BCNT_W-1:0] buf_count;
  logic              buf_empty;
  fetch_entry_t      buf_head;
  fetch_entry_t      push_entry;
  logic [CRED_W-1:0] credit;
  logic              redirect, issue, flush, push, pop, present;

  assign redirect = fetch_if.redirect_valid_in;
  assign flush    = rst_in || redirect;

  // Credit counts every word already owed to the buffer: reads still in the
  // memory pipe plus words sitting in the buffer.
  always_comb begin
    credit = CRED_W'(buf_count);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      credit = credit + CRED_W'(shadow_q[i].valid);
    end
  end

  assign issue = !rst_in && !redirect && (credit < CRED_W'(BUF_DEPTH));

  // The last shadow stage lines up with the cycle its memory data returns.
  assign push       = shadow_q[MEM_LATENCY-1].valid;
  assign push_entry = '{instruction: fetch_if.imem_data_in, pc: shadow_q[MEM_LATENCY-1].pc};

  assign present = !buf_empty && !flush;
  assign pop     = present && fetch_if.iq_ready_in;

  always_comb begin
    pc_d        = pc_q;
    shadow_d[0] = '{valid: issue, pc: pc_q};
    for (int i = 1; i < MEM_LATENCY; i++) begin
      shadow_d[i] = shadow_q[i-1];
    end
    if (redirect) begin
      pc_d = {fetch_if.redirect_pc_in[XLEN-1:2], 2'b00};
      // Reads already in flight become stale; their data is dropped on return.
      for (int i = 0; i < MEM_LATENCY; i++) begin
        shadow_d[i].valid = 1'b0;
      end
    end else if (issue) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .flush_i      (flush),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (buf_head),
    .empty_o      (buf_empty),
    .count_o      (buf_count)
  );

  assign fetch_if.imem_req_out       = issue;
  assign fetch_if.imem_addr_out      = pc_q;
  assign fetch_if.iq_valid_out       = present;
  assign fetch_if.iq_instruction_out = present ? buf_head.instruction : '0;
  assign fetch_if.iq_pc_out          = present ? buf_head.pc : '0;

endmodule
